tx_axis_arbiter: RTL and testbench

- Frame-granular round-robin arbiter that shares the single TX MAC AXI-Stream slave input (64-bit data, 8-bit keep) among NUM_SRC user sources.
- Sits directly upstream of the TX MAC. The MAC needs tvalid held continuously for a whole frame, so grants never switch mid-frame.
- Also provides a per-source enable mask and abort detection for sources that drop tvalid mid-frame.

---
 rtl/tx_arb_pkg.sv | 19 +
 rtl/tx_axis_arbiter_rr_pick.sv | 43 ++++
 rtl/tx_axis_arbiter.sv | 161 ++++++++++++++++
 tb/tb_tx_axis_arbiter.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// ---------------------------------------------------------------------------
// tx_arb_pkg
// Shared types and constants for the TX AXI-Stream arbiter.
//   tx_arb_state_t : arbiter FSM state (ARB = choosing a source, FWD = frame
//                    in flight from the granted source)
//   AXIS_DATA_W    : MAC-side AXIS data width
//   AXIS_KEEP_W    : MAC-side AXIS keep width
// ---------------------------------------------------------------------------
package tx_arb_pkg;

  typedef enum logic {
    ARB = 1'b0,
    FWD = 1'b1
  } tx_arb_state_t;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;

endpackage

// File: rtl/tx_axis_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker. Scans last+1, last+2, ... modulo N
// and returns the first requesting index.
//   N    : number of requesters (2..16, any value, not only powers of two)
//   req  : request vector, one bit per requester
//   last : index served most recently (lowest priority this round)
//   pick : chosen index (0 when nothing requests)
//   any  : at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick
  import tx_arb_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] pick,
  output logic         any
);

  logic [W-1:0] idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = last;
    for (int i = 0; i < N; i++) begin
      // Explicit wrap so non-power-of-two N never visits an unused index.
      if (idx == W'(N - 1)) begin
        idx = '0;
      end else begin
        idx = idx + W'(1);
      end
      if (!any && req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_axis_arbiter.sv
// ---------------------------------------------------------------------------
// tx_axis_arbiter
// Frame-granular round-robin arbiter sharing the TX MAC AXI-Stream input
// among NUM_SRC sources. A grant is held for a whole frame; it ends on an
// accepted tlast beat, or when the granted source drops tvalid after at
// least one beat was accepted (abort).
//
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   s_axis_*              : per-source AXIS slaves, source k in slice k
//   m_axis_*              : AXIS master towards the MAC
//   i_src_enable          : per-source enable, sampled only while arbitrating
//   o_grant/o_grant_valid : granted source index and grant-active flag
//   o_abort               : one-cycle pulse after a mid-frame tvalid drop
//   o_frame_count         : (only with TX_ARB_STATS_EN) per-source 32-bit
//                           completed-frame counters, source k in [k*32+:32]
//
// Optional build macro: TX_ARB_STATS_EN adds the frame counters.
// ---------------------------------------------------------------------------
module tx_axis_arbiter
  import tx_arb_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int GRANT_W = $clog2(NUM_SRC)
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [NUM_SRC*AXIS_DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_SRC*AXIS_KEEP_W-1:0] s_axis_tkeep,
  input  logic [NUM_SRC-1:0]             s_axis_tvalid,
  input  logic [NUM_SRC-1:0]             s_axis_tlast,
  output logic [NUM_SRC-1:0]             s_axis_tready,
  output logic [AXIS_DATA_W-1:0]         m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0]         m_axis_tkeep,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready,
  input  logic [NUM_SRC-1:0]             i_src_enable,
  output logic [GRANT_W-1:0]             o_grant,
  output logic                           o_grant_valid,
  output logic                           o_abort
`ifdef TX_ARB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0]          o_frame_count
`endif
);

  tx_arb_state_t      state_reg;
  logic [GRANT_W-1:0] grant_reg;
  logic [GRANT_W-1:0] last_grant_reg;
  logic               grant_valid_reg;
  logic               abort_reg;
  logic               beat_seen_reg;

  logic [NUM_SRC-1:0] req;
  logic [GRANT_W-1:0] pick;
  logic               pick_any;
  logic               fwd;
  logic               accept;

  // Per-source views of the packed input buses.
  logic [AXIS_DATA_W-1:0] src_data [NUM_SRC];
  logic [AXIS_KEEP_W-1:0] src_keep [NUM_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign src_data[gi] = s_axis_tdata[gi*AXIS_DATA_W +: AXIS_DATA_W];
      assign src_keep[gi] = s_axis_tkeep[gi*AXIS_KEEP_W +: AXIS_KEEP_W];
    end
  endgenerate

  assign req = s_axis_tvalid & i_src_enable;

  rr_pick #(
    .N (NUM_SRC)
  ) u_rr_pick (
    .req  (req),
    .last (last_grant_reg),
    .pick (pick),
    .any  (pick_any)
  );

  // Output mux: only live in FWD, everything reads zero while arbitrating.
  assign fwd           = (state_reg == FWD);
  assign m_axis_tdata  = fwd ? src_data[grant_reg] : '0;
  assign m_axis_tkeep  = fwd ? src_keep[grant_reg] : '0;
  assign m_axis_tvalid = fwd & s_axis_tvalid[grant_reg];
  assign m_axis_tlast  = fwd & s_axis_tlast[grant_reg];
  assign accept        = m_axis_tvalid & m_axis_tready;

  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_ready
      assign s_axis_tready[gi] = fwd && (grant_reg == GRANT_W'(gi)) && m_axis_tready;
    end
  endgenerate

  assign o_grant       = grant_reg;
  assign o_grant_valid = grant_valid_reg;
  assign o_abort       = abort_reg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg       <= ARB;
      grant_reg       <= '0;
      grant_valid_reg <= 1'b0;
      abort_reg       <= 1'b0;
      last_grant_reg  <= GRANT_W'(NUM_SRC - 1);
      beat_seen_reg   <= 1'b0;
    end else begin
      abort_reg <= 1'b0;
      case (state_reg)
        ARB: begin
          if (pick_any) begin
            grant_reg       <= pick;
            grant_valid_reg <= 1'b1;
            beat_seen_reg   <= 1'b0;
            state_reg       <= FWD;
          end
        end
        FWD: begin
          if (accept) begin
            beat_seen_reg <= 1'b1;
            if (m_axis_tlast) begin
              last_grant_reg  <= grant_reg;
              grant_valid_reg <= 1'b0;
              state_reg       <= ARB;
            end
          end else if (beat_seen_reg && !s_axis_tvalid[grant_reg]) begin
            // Source vanished mid-frame; the pulse lands together with the
            // return to ARB. A gap before the first beat is just a late start.
            abort_reg       <= 1'b1;
            last_grant_reg  <= grant_reg;
            grant_valid_reg <= 1'b0;
            state_reg       <= ARB;
          end
        end
        default: begin
          state_reg <= ARB;
        end
      endcase
    end
  end

`ifdef TX_ARB_STATS_EN
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_stats
      logic [31:0] frame_cnt_reg;
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          frame_cnt_reg <= '0;
        end else if (accept && m_axis_tlast && (grant_reg == GRANT_W'(gi))) begin
          frame_cnt_reg <= frame_cnt_reg + 32'd1;
        end
      end
      assign o_frame_count[gi*32 +: 32] = frame_cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tx_axis_arbiter
// Self-checking bench for tx_axis_arbiter (NUM_SRC=4). Source drivers hold
// queued frames; a transaction-level reference tracks who should own the
// MAC port, which beats should appear, and when aborts should pulse.
// ---------------------------------------------------------------------------
module tb_tx_axis_arbiter;

  localparam int N  = 4;
  localparam int GW = 2;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic [N*64-1:0]   s_axis_tdata = '0;
  logic [N*8-1:0]    s_axis_tkeep = '0;
  logic [N-1:0]      s_axis_tvalid = '0;
  logic [N-1:0]      s_axis_tlast = '0;
  logic [N-1:0]      s_axis_tready;
  logic [63:0]       m_axis_tdata;
  logic [7:0]        m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b1;
  logic [N-1:0]      i_src_enable = '1;
  logic [GW-1:0]     o_grant;
  logic              o_grant_valid;
  logic              o_abort;
`ifdef TX_ARB_STATS_EN
  logic [N*32-1:0]   o_frame_count;
`endif

  always #5 i_clk = ~i_clk;

  tx_axis_arbiter #(.NUM_SRC(N)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .i_src_enable  (i_src_enable),
    .o_grant       (o_grant),
    .o_grant_valid (o_grant_valid),
    .o_abort       (o_abort)
`ifdef TX_ARB_STATS_EN
    ,
    .o_frame_count (o_frame_count)
`endif
  );

  // Source driver state: pending beats per source.
  logic [63:0] q_data [N][$];
  logic [7:0]  q_keep [N][$];
  logic        q_last [N][$];
  bit          in_frame [N];
  logic [N-1:0] drop_mask = '0;
  bit          rand_start = 1'b0;

  // Reference model.
  bit exp_busy, exp_seen, exp_abort;
  int exp_g, exp_last;
  int exp_frames [N];
  int grant_log [$];

  int n_cmp = 0;
  int n_fail = 0;
  int abort_seen = 0;
  int beats_acc = 0;
  int beats_pushed = 0;
  int popped [N];

  function automatic int rr_next(input int last, input logic [N-1:0] req);
    for (int i = 1; i <= N; i++) begin
      if (req[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  function automatic bit queues_empty();
    for (int k = 0; k < N; k++) if (q_data[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_frame(input int k, input int len, input logic [7:0] last_keep);
    for (int b = 0; b < len; b++) begin
      q_data[k].push_back({$urandom(), $urandom()});
      q_keep[k].push_back((b == len - 1) ? last_keep : 8'hFF);
      q_last[k].push_back(b == len - 1);
    end
    beats_pushed += len;
  endtask

  task automatic flush_src(input int k);
    while (in_frame[k] && q_data[k].size() > 0) begin
      in_frame[k] = !q_last[k][0];
      void'(q_data[k].pop_front());
      void'(q_keep[k].pop_front());
      void'(q_last[k].pop_front());
      beats_pushed--;
    end
    in_frame[k] = 1'b0;
  endtask

  task automatic model_reset();
    exp_busy  = 1'b0;
    exp_seen  = 1'b0;
    exp_abort = 1'b0;
    exp_g     = 0;
    exp_last  = N - 1;
    for (int k = 0; k < N; k++) exp_frames[k] = 0;
  endtask

  // Drive one cycle from the queues, score the DUT against the reference,
  // then advance drivers and reference. Starts and ends at a negedge.
  task automatic run_cycle(input bit rdy);
    logic [N-1:0] req;
    logic [63:0]  ed;
    logic [7:0]   ek;
    logic         ev, el;
    logic [N-1:0] er;
    for (int k = 0; k < N; k++) begin
      bit v;
      v = (q_data[k].size() > 0) && !drop_mask[k] &&
          (in_frame[k] || !rand_start || ($urandom_range(0, 1) == 1));
      s_axis_tvalid[k] = v;
      if (v) begin
        s_axis_tdata[k*64 +: 64] = q_data[k][0];
        s_axis_tkeep[k*8 +: 8]   = q_keep[k][0];
        s_axis_tlast[k]          = q_last[k][0];
      end else begin
        s_axis_tdata[k*64 +: 64] = {$urandom(), $urandom()};
        s_axis_tkeep[k*8 +: 8]   = 8'($urandom());
        s_axis_tlast[k]          = 1'($urandom());
      end
    end
    m_axis_tready = rdy;
    #1;
    er = '0;
    if (exp_busy) begin
      ev = s_axis_tvalid[exp_g];
      el = s_axis_tlast[exp_g];
      ed = s_axis_tdata[exp_g*64 +: 64];
      ek = s_axis_tkeep[exp_g*8 +: 8];
      er[exp_g] = rdy;
    end else begin
      ev = 1'b0; el = 1'b0; ed = '0; ek = '0;
    end
    n_cmp++;
    if (o_grant_valid !== exp_busy) begin
      n_fail++;
      $display("FAIL grant_valid @%0t: got %b want %b", $time, o_grant_valid, exp_busy);
    end
    if (exp_busy) begin
      n_cmp++;
      if (o_grant !== GW'(exp_g)) begin
        n_fail++;
        $display("FAIL grant @%0t: got %0d want %0d", $time, o_grant, exp_g);
      end
    end
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== {ev, el, ek, ed}) begin
      n_fail++;
      $display("FAIL m_axis @%0t: got v%b l%b k%h d%h want v%b l%b k%h d%h", $time,
               m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, ev, el, ek, ed);
    end
    n_cmp++;
    if (s_axis_tready !== er) begin
      n_fail++;
      $display("FAIL s_tready @%0t: got %b want %b", $time, s_axis_tready, er);
    end
    n_cmp++;
    if (o_abort !== exp_abort) begin
      n_fail++;
      $display("FAIL abort @%0t: got %b want %b", $time, o_abort, exp_abort);
    end
    if (o_abort === 1'b1) abort_seen++;
    if (m_axis_tvalid && m_axis_tready) beats_acc++;
    // Sources pop on their own handshake.
    for (int k = 0; k < N; k++) begin
      if (s_axis_tvalid[k] && s_axis_tready[k] && q_data[k].size() > 0) begin
        popped[k]++;
        in_frame[k] = !q_last[k][0];
        void'(q_data[k].pop_front());
        void'(q_keep[k].pop_front());
        void'(q_last[k].pop_front());
      end
    end
    // Reference: who owns the port next cycle.
    exp_abort = 1'b0;
    if (!exp_busy) begin
      req = s_axis_tvalid & i_src_enable;
      if (req != '0) begin
        exp_g = rr_next(exp_last, req);
        grant_log.push_back(exp_g);
        exp_busy = 1'b1;
        exp_seen = 1'b0;
      end
    end else if (s_axis_tvalid[exp_g] && rdy) begin
      exp_seen = 1'b1;
      if (s_axis_tlast[exp_g]) begin
        exp_frames[exp_g]++;
        exp_last = exp_g;
        exp_busy = 1'b0;
      end
    end else if (exp_seen && !s_axis_tvalid[exp_g]) begin
      exp_abort = 1'b1;
      exp_last  = exp_g;
      exp_busy  = 1'b0;
    end
    @(negedge i_clk);
  endtask

  task automatic drain(input int max, output int cycles);
    cycles = 0;
    while (!queues_empty() && cycles < max) begin
      run_cycle(1'b1);
      cycles++;
    end
  endtask

  // Holds reset across one posedge with inputs untouched; returns at negedge+1.
  task automatic apply_reset();
    i_reset = 1'b1;
    @(negedge i_clk);
    #1;
  endtask

  task automatic release_reset();
    i_reset = 1'b0;
    s_axis_tvalid = '0;
    for (int k = 0; k < N; k++) flush_src(k);
    model_reset();
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    s_axis_tvalid = '1;
    s_axis_tdata  = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
    apply_reset();
    n_cmp++;
    if ({o_grant_valid, o_grant, o_abort} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got gv%b g%0d ab%b want 0", o_grant_valid, o_grant, o_abort);
    end
    n_cmp++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== '0 || s_axis_tready !== '0) begin
      n_fail++;
      $display("FAIL reset_axis: got mv%b md%h rdy%b want 0", m_axis_tvalid, m_axis_tdata, s_axis_tready);
    end
`ifdef TX_ARB_STATS_EN
    n_cmp++;
    if (o_frame_count !== '0) begin
      n_fail++;
      $display("FAIL reset_count: got %h want 0", o_frame_count);
    end
`endif
    release_reset();
  endtask

  task automatic test_single_source();
    int cyc, b0;
    grant_log.delete();
    b0 = beats_acc;
    push_frame(0, 3, 8'h0F);
    run_cycle(1'b1);
    n_cmp++;
    if (o_grant_valid !== 1'b1 || o_grant !== 2'd0 || m_axis_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency: got gv%b g%0d mv%b want gv1 g0 mv1", o_grant_valid, o_grant, m_axis_tvalid);
    end
    drain(20, cyc);
    run_cycle(1'b1);
    n_cmp++;
    if (beats_acc - b0 != 3 || grant_log.size() != 1 || o_grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_frame: got beats %0d grants %0d gv%b want 3 1 0",
               beats_acc - b0, grant_log.size(), o_grant_valid);
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    int want [6] = '{0, 1, 2, 3, 0, 1};
    apply_reset();
    release_reset();
    grant_log.delete();
    push_frame(0, 2, 8'hFF); push_frame(0, 2, 8'h03);
    push_frame(1, 2, 8'h01); push_frame(1, 2, 8'h7F);
    push_frame(2, 2, 8'h3F); push_frame(3, 2, 8'h1F);
    drain(100, cyc);
    n_cmp++;
    if (cyc != 18) begin
      n_fail++;
      $display("FAIL rr_cycles: got %0d want 18", cyc);
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (grant_log.size() <= i || grant_log[i] != want[i]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", i,
                 (grant_log.size() > i) ? grant_log[i] : -1, want[i]);
      end
    end
  endtask

  task automatic test_hold_grant();
    int cyc;
    grant_log.delete();
    push_frame(2, 4, 8'hFF);
    for (int i = 0; i < 3; i++) run_cycle(1'b1);
    push_frame(0, 2, 8'h0F);
    push_frame(3, 2, 8'h07);
    run_cycle(1'b1);
    n_cmp++;
    if (s_axis_tready[0] !== 1'b0 || o_grant !== 2'd2) begin
      n_fail++;
      $display("FAIL hold_grant: got rdy0 %b g%0d want 0 2", s_axis_tready[0], o_grant);
    end
    drain(50, cyc);
    n_cmp++;
    if (grant_log.size() != 3 || grant_log[0] != 2 || grant_log[1] != 3 || grant_log[2] != 0) begin
      n_fail++;
      $display("FAIL hold_order: got %p want 2 3 0", grant_log);
    end
  endtask

  task automatic test_backpressure();
    int cyc, b0, p0;
    logic [63:0] held;
    b0 = beats_acc;
    p0 = popped[1];
    held = '0;
    push_frame(1, 6, 8'h3F);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) held = q_data[1][0];
      run_cycle(!(i >= 3 && i < 8));
      if (i >= 3) begin
        n_cmp++;
        if (m_axis_tdata !== held || s_axis_tready[1] !== 1'b0 || popped[1] - p0 != 2) begin
          n_fail++;
          $display("FAIL bp_hold[%0d]: got d%h rdy%b pops %0d want d%h rdy0 pops 2",
                   i, m_axis_tdata, s_axis_tready[1], popped[1] - p0, held);
        end
      end
    end
    drain(30, cyc);
    n_cmp++;
    if (beats_acc - b0 != 6) begin
      n_fail++;
      $display("FAIL bp_beats: got %0d want 6", beats_acc - b0);
    end
  endtask

  task automatic test_abort();
    int cyc, p0, a0;
    grant_log.delete();
    p0 = popped[1];
    a0 = abort_seen;
    push_frame(1, 5, 8'hFF);
    run_cycle(1'b1);
    push_frame(0, 2, 8'h0F);
    push_frame(2, 2, 8'hF0);
    cyc = 0;
    while (popped[1] - p0 < 2 && cyc < 20) begin run_cycle(1'b1); cyc++; end
    drop_mask[1] = 1'b1;
    cyc = 0;
    while (abort_seen == a0 && cyc < 10) begin run_cycle(1'b1); cyc++; end
    n_cmp++;
    if (o_grant_valid !== 1'b1 || o_grant !== 2'd2) begin
      n_fail++;
      $display("FAIL abort_next: got gv%b g%0d want gv1 g2", o_grant_valid, o_grant);
    end
    flush_src(1);
    drop_mask[1] = 1'b0;
    drain(40, cyc);
    run_cycle(1'b1);
    n_cmp++;
    if (abort_seen - a0 != 1) begin
      n_fail++;
      $display("FAIL abort_pulses: got %0d want 1", abort_seen - a0);
    end
    n_cmp++;
    if (grant_log.size() != 3 || grant_log[0] != 1 || grant_log[1] != 2 || grant_log[2] != 0) begin
      n_fail++;
      $display("FAIL abort_order: got %p want 1 2 0", grant_log);
    end
  endtask

  task automatic test_random();
    int cyc, b0, p0;
    b0 = beats_acc;
    p0 = beats_pushed;
    rand_start = 1'b1;
    for (int k = 0; k < N; k++)
      for (int f = 0; f < 3; f++)
        push_frame(k, $urandom_range(1, 6), 8'($urandom_range(1, 255)));
    for (int c = 0; c < 400; c++) begin
      if (c % 16 == 0) i_src_enable = 4'($urandom());
      if (c % 50 == 25) push_frame($urandom_range(0, N - 1), $urandom_range(1, 6), 8'($urandom_range(1, 255)));
      run_cycle($urandom_range(0, 3) != 0);
    end
    i_src_enable = '1;
    rand_start = 1'b0;
    drain(3000, cyc);
    run_cycle(1'b1);
    n_cmp++;
    if (!queues_empty() || beats_acc - b0 != beats_pushed - p0) begin
      n_fail++;
      $display("FAIL random_beats: got %0d want %0d", beats_acc - b0, beats_pushed - p0);
    end
`ifdef TX_ARB_STATS_EN
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (o_frame_count[k*32 +: 32] !== 32'(exp_frames[k])) begin
        n_fail++;
        $display("FAIL frame_count[%0d]: got %0d want %0d", k, o_frame_count[k*32 +: 32], exp_frames[k]);
      end
    end
`endif
  endtask

  task automatic test_enable_reset();
    int cyc;
    int want [5] = '{1, 3, 1, 3, 0};
    apply_reset();
    release_reset();
    grant_log.delete();
    i_src_enable = 4'b1010;
    for (int k = 0; k < N; k++) begin
      push_frame(k, 2, 8'hFF);
      push_frame(k, 2, 8'h0F);
    end
    for (int i = 0; i < 12; i++) run_cycle(1'b1);
    i_src_enable = '1;
    run_cycle(1'b1);
    run_cycle(1'b1);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (grant_log.size() <= i || grant_log[i] != want[i]) begin
        n_fail++;
        $display("FAIL en_order[%0d]: got %0d want %0d", i,
                 (grant_log.size() > i) ? grant_log[i] : -1, want[i]);
      end
    end
    apply_reset();
    n_cmp++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== '0 || o_grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_reset: got mv%b rdy%b gv%b want 0 0 0", m_axis_tvalid, s_axis_tready, o_grant_valid);
    end
`ifdef TX_ARB_STATS_EN
    n_cmp++;
    if (o_frame_count !== '0) begin
      n_fail++;
      $display("FAIL midframe_count: got %h want 0", o_frame_count);
    end
`endif
    release_reset();
    drain(100, cyc);
    n_cmp++;
    if (!queues_empty()) begin
      n_fail++;
      $display("FAIL post_reset_drain: got %0d cycles, queues not empty want empty", cyc);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) popped[k] = 0;
    model_reset();
    @(negedge i_clk);
    test_reset();
    test_single_source();
    test_round_robin();
    test_hold_grant();
    test_backpressure();
    test_abort();
    test_random();
    test_enable_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
